// File: rtl/enc_pkg.sv
// Shared constants and types for the 32-to-5 request scanner.
package enc_pkg;

    localparam int N = 32;  // number of request lines (fixed)
    localparam int W = 5;   // index width, log2(N)

    typedef logic [N-1:0] req_vec_t;
    typedef logic [W-1:0] idx_t;

endpackage : enc_pkg

// File: rtl/prio_find32.sv
// Combinational first-set-bit finder over a 32-bit vector.
// The search begins at start_i and wraps from bit 31 back to bit 0.
// A start of zero gives plain lowest-index-wins priority.
module prio_find32
    import enc_pkg::*;
(
    input  logic [N-1:0] vec_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    logic [N-1:0] rot;
    logic [W-1:0] ofs;

    // Rotate so start_i lands on bit 0, then pick the lowest set bit of the rotation.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
        rot     = '0;
        ofs     = '0;
        found_o = |vec_i;
        for (int i = 0; i < N; i++) begin
            rot[i] = vec_i[idx_t'(i) + start_i];
        end
        // Scan downward so the last hit written is the lowest set offset.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                ofs = idx_t'(i);
            end
        end
        // Undo the rotation; the 5-bit sum wraps naturally.
        idx_o = start_i + ofs;
    end

endmodule : prio_find32

// File: rtl/encode32to5_scan.sv
// 32-to-5 request encoder with a valid/ready index stream.
// Posted request bits accumulate in a pending register; each accepted
// transfer emits one pending bit's index and clears it from the set.
// Build option: define ENC_ROUND_ROBIN_EN for round-robin arbitration
// (search from a rotating pointer); otherwise lowest index wins.
module encode32to5_scan
    import enc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req_in,
    input  logic         req_valid,
    output logic [W-1:0] idx_out,
    output logic         idx_valid,
    input  logic         idx_ready,
    output logic [N-1:0] pending,
    output logic         empty
);

    req_vec_t pending_q, pending_d;
    idx_t     idx_out_q, idx_out_d;
    logic     idx_valid_q, idx_valid_d;

    idx_t     start;
    idx_t     sel;
    logic     found;
    logic     slot_free;
    logic     load;
    req_vec_t sel_onehot;

`ifdef ENC_ROUND_ROBIN_EN
    idx_t ptr_q, ptr_d;

    // Pointer advances past the bit just loaded; 31 + 1 wraps to 0.
    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = sel + idx_t'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign start = ptr_q;
`else
    assign start = '0;
`endif

    prio_find32 u_find (
        .vec_i   (pending_q),
        .start_i (start),
        .idx_o   (sel),
        .found_o (found)
    );

    // Next-state for the output slot and the pending set.
    always_comb begin
        slot_free   = !idx_valid_q || idx_ready;
        load        = en && slot_free && found;
        idx_out_d   = idx_out_q;
        idx_valid_d = idx_valid_q;
        if (load) begin
            idx_out_d   = sel;
            idx_valid_d = 1'b1;
        end else if (slot_free) begin
            idx_valid_d = 1'b0;
        end
        // Only a bit actually loaded is cleared; a same-edge re-post keeps it pending.
        sel_onehot = load ? (req_vec_t'(1) << sel) : '0;
        pending_d  = (pending_q & ~sel_onehot) | (req_valid ? req_in : '0);
    end

    // Pending set and output register; reset drops any held index at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            idx_out_q   <= '0;
            idx_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            pending_q   <= pending_d;
            idx_out_q   <= idx_out_d;
            idx_valid_q <= idx_valid_d;
        end
    end

    assign idx_out   = idx_out_q;
    assign idx_valid = idx_valid_q;
    assign pending   = pending_q;
    assign empty     = (pending_q == '0) && !idx_valid_q;

endmodule : encode32to5_scan

// File: tb/tb_encode32to5_scan.sv
// Directed self-checking bench for encode32to5_scan.
// Expected values are hand-computed; mode-dependent orders select on ENC_ROUND_ROBIN_EN.
module tb_encode32to5_scan;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] req_in;
    logic        req_valid;
    logic [4:0]  idx_out;
    logic        idx_valid;
    logic        idx_ready;
    logic [31:0] pending;
    logic        empty;

    int checks   = 0;
    int failures = 0;

    encode32to5_scan dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_in    (req_in),
        .req_valid (req_valid),
        .idx_out   (idx_out),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .pending   (pending),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    logic [4:0] rr_a, rr_b;

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        req_in    = '0;
        req_valid = 1'b0;
        idx_ready = 1'b1;
        #2;
        check("rst_idx_valid", 32'(idx_valid), 32'd0);
        check("rst_idx_out",   32'(idx_out),   32'd0);
        check("rst_pending",   pending,        32'h0);
        check("rst_empty",     32'(empty),     32'd1);
        #2;
        rst_n = 1'b1;
        tick();

        // Single bit 0: emitted for exactly one cycle, one edge after posting.
        req_in = 32'h0000_0001; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("t1_pend_posted", pending,          32'h1);
        check("t1_valid_early", 32'(idx_valid),   32'd0);
        check("t1_not_empty",   32'(empty),       32'd0);
        tick();
        check("t1_valid",       32'(idx_valid),   32'd1);
        check("t1_idx",         32'(idx_out),     32'd0);
        check("t1_pend_clear",  pending,          32'h0);
        tick();
        check("t1_valid_drop",  32'(idx_valid),   32'd0);
        check("t1_empty",       32'(empty),       32'd1);

        // Three bits back-to-back: 0, 4, 31 (same order from ptr 0 in either mode).
        do_reset();
        req_in = 32'h8000_0011; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("t2_pend", pending, 32'h8000_0011);
        tick();
        check("t2_v0",   32'(idx_valid), 32'd1);
        check("t2_i0",   32'(idx_out),   32'd0);
        check("t2_p0",   pending,        32'h8000_0010);
        tick();
        check("t2_v1",   32'(idx_valid), 32'd1);
        check("t2_i1",   32'(idx_out),   32'd4);
        tick();
        check("t2_v2",   32'(idx_valid), 32'd1);
        check("t2_i2",   32'(idx_out),   32'd31);
        check("t2_p2",   pending,        32'h0);
        tick();
        check("t2_done", 32'(idx_valid), 32'd0);

        // Stall: index 1 held while ready low, then 1 accepted and 2 follows.
        idx_ready = 1'b0;
        req_in = 32'h0000_0006; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("t3_load_v", 32'(idx_valid), 32'd1);
        check("t3_load_i", 32'(idx_out),   32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_stall_v", 32'(idx_valid), 32'd1);
            check("t3_stall_i", 32'(idx_out),   32'd1);
        end
        check("t3_stall_p", pending, 32'h4);
        idx_ready = 1'b1;
        tick();
        check("t3_next_v", 32'(idx_valid), 32'd1);
        check("t3_next_i", 32'(idx_out),   32'd2);
        check("t3_next_p", pending,        32'h0);
        tick();
        check("t3_done",   32'(idx_valid), 32'd0);

        // Pointer behaviour: emit 4, then post bits 0 and 5.
`ifdef ENC_ROUND_ROBIN_EN
        rr_a = 5'd5; rr_b = 5'd0;
`else
        rr_a = 5'd0; rr_b = 5'd5;
`endif
        req_in = 32'h0000_0010; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("t4_i4", 32'(idx_out), 32'd4);
        req_in = 32'h0000_0021; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("t4_gap_v", 32'(idx_valid), 32'd0);
        check("t4_gap_p", pending,        32'h21);
        tick();
        check("t4_first",  32'(idx_out), 32'(rr_a));
        tick();
        check("t4_second", 32'(idx_out), 32'(rr_b));
        check("t4_second_v", 32'(idx_valid), 32'd1);
        tick();
        check("t4_done", 32'(idx_valid), 32'd0);

        // en low: pending accumulates, nothing loads; then all 32 in order.
        do_reset();
        en = 1'b0;
        req_in = 32'hFFFF_FFFF; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("t5_hold_v", 32'(idx_valid), 32'd0);
        check("t5_hold_p", pending,        32'hFFFF_FFFF);
        // Posting an already-pending bit changes nothing.
        req_in = 32'h0000_0100; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("t5_idem_p", pending, 32'hFFFF_FFFF);
        en = 1'b1;
        for (int k = 0; k < 32; k++) begin
            tick();
            check("t5_seq_v", 32'(idx_valid), 32'd1);
            check("t5_seq_i", 32'(idx_out),   32'(k));
        end
        check("t5_pend_empty", pending, 32'h0);
        tick();
        check("t5_done", 32'(empty), 32'd1);

        // Asynchronous reset mid-stream drops the held index without a clock edge.
        req_in = 32'h0000_0003; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("t6_pre_v", 32'(idx_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_v", 32'(idx_valid), 32'd0);
        check("t6_async_i", 32'(idx_out),   32'd0);
        check("t6_async_p", pending,        32'h0);
        check("t6_async_e", 32'(empty),     32'd1);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_quiet_v", 32'(idx_valid), 32'd0);
        end
        check("t6_quiet_e", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_encode32to5_scan

// File: doc/encode32to5_scan.md
Name: encode32to5_scan

Overview:
- Inverse companion of the 5-to-32 decoder.
- Accumulates a 32-bit vector of pending request bits and emits their 5-bit binary indices, one per accepted transfer, over a valid/ready stream.
- Each emitted bit is cleared from the pending set.
- Sits between interrupt/request sources and the FIFO write side; the index stream typically feeds a FIFO.

Parameters:
- N, 32, number of request lines; fixed at 32, exposed for readability only.
- W, 5, index width, equal to log2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scan enable; when low, no new index is selected.
- req_in  input  32  request bits to post.
- req_valid  input  1  when high, req_in is ORed into pending at this clock edge.
- idx_out  output  5  encoded index of the emitted request.
- idx_valid  output  1  idx_out holds a valid index.
- idx_ready  input  1  downstream accepts idx_out when idx_valid && idx_ready.
- pending  output  32  current pending register.
- empty  output  1  high when pending == 0 and idx_valid == 0.

Behaviour:
- Reset (asynchronous, rst_n low): pending = 0, idx_out = 0, idx_valid = 0, empty = 1, scan pointer ptr = 0. Applies immediately, mid-operation included; a held index is dropped.
- Slot free: the output register is free when !idx_valid || (idx_valid && idx_ready).
- Selection: combinational over the current pending register. sel = first set bit of pending searched according to the arbitration mode (see Optional Feature). sel_onehot = decoded sel, or 0 if nothing is selected.
- Load: if en && slot free && pending != 0, then at the clock edge idx_out <= sel and idx_valid <= 1.
- Otherwise, if slot free, idx_valid <= 0 and idx_out holds its value.
- Stall: if idx_valid && !idx_ready, idx_out and idx_valid hold stable; protocol rule, no change while stalled.
- Pending update at each edge: pending <= (pending & ~sel_onehot) | (req_valid ? req_in : 0).
- Simultaneous post and selection of the same bit: the bit remains pending and is emitted again later. Exactly one emission per posting is not guaranteed for bits re-posted while in flight.
- Posting an already-pending bit has no effect (idempotent OR).
- Latency: a bit posted at edge t with the slot free and en high gives idx_valid high after edge t+1. Back-to-back throughput is one index per cycle with idx_ready held high.
- en low: pending still accumulates. An index already in idx_out still completes its handshake. No new load occurs.
- Fixed width: no wrap arithmetic beyond the 5-bit pointer in round-robin mode.
- empty is combinational from registered state.

Optional Feature:
- Macro: ENC_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - Search starts at ptr and wraps 31 -> 0.
  - On each load, ptr <= sel + 1 (5-bit natural wrap, 31 + 1 = 0).
  - Reset ptr = 0.
- Undefined: fixed priority, lowest set index wins. ptr is not implemented.

Decomposition:
- Package enc_pkg:
  - constants N = 32, W = 5.
  - typedef req_vec_t (logic [N-1:0]).
  - typedef idx_t (logic [W-1:0]).
- One sub-module: prio_find32, a combinational first-set-bit finder.
  - Inputs: vector, start offset (offset tied to 0 in fixed mode).
  - Outputs: index, found flag.
- Pending register, output register and pointer remain in the top.

Test Plan:
- Reset, then req_in = 32'h0000_0001 with req_valid for 1 cycle, idx_ready = 1 -> idx_out = 0 with idx_valid high for exactly 1 cycle one edge later; pending = 0; empty = 1.
- Post 32'h8000_0011, idx_ready = 1 -> indices 0, 4, 31 on consecutive cycles. Round-robin mode gives the same order from ptr = 0.
- Post 32'h0000_0006, idx_ready low for 5 cycles -> idx_out = 1 held stable with idx_valid high. Then ready high -> 1 then 2 emitted.
- Round-robin: emit index 4, then post 32'h0000_0021 -> next emission is 5 and then 0 (ptr wraps). Fixed mode gives 0 then 5.
- en = 0 while posting 32'hFFFF_FFFF -> idx_valid stays 0 and pending = FFFF_FFFF. Then en = 1 -> 32 indices emitted, 0..31 in order.
- Assert rst_n low asynchronously mid-stream with idx_valid high -> outputs clear immediately with no clock edge. Release -> no emission until a new post.
